// File: rtl/sprite_fetch_arbiter_if.sv
// Bus bundle between the object controllers, the arbiter and the shared sprite memory.
// The master side is the environment (requesters plus memory); the slave side is the arbiter.
interface sprite_fetch_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 12
);
  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]             gnt;
  logic                           mem_rd;
  logic [ADDR_W-1:0]              mem_addr;
  logic [7:0]                     mem_data;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [7:0]                     rsp_data;

  modport master (
    output req, req_addr, mem_data,
    input  gnt, mem_rd, mem_addr, rsp_valid, rsp_data
  );

  modport slave (
    input  req, req_addr, mem_data,
    output gnt, mem_rd, mem_addr, rsp_valid, rsp_data
  );
endinterface

// File: rtl/sprite_fetch_arbiter.sv
// Round-robin arbiter sharing one fixed-latency sprite memory among object controllers.
// A frame_start pulse stops granting until every outstanding read has returned its response.
module sprite_fetch_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 12,
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_start,
  output logic draining,
  sprite_fetch_arbiter_if.slave bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(NUM_REQ - 1);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t state, state_next;

  logic [IDX_W-1:0]             last;
  logic [IDX_W-1:0]             pick_idx;
  logic                         pick_any;
  int                           cand;
  logic                         grant_en;
  logic                         accept;
  logic [NUM_REQ-1:0]           gnt;

  logic                         mem_rd_q;
  logic [ADDR_W-1:0]            mem_addr_q;
  logic [MEM_LAT:0]             tag_valid;
  logic [MEM_LAT:0][IDX_W-1:0]  tag_idx;
  logic                         pipe_empty;
  logic [NUM_REQ-1:0]           rsp_valid_q;
  logic [7:0]                   rsp_data_q;

  assign pipe_empty = ~|tag_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // A frame_start seen while draining is deliberately ignored; the drain ends on its own.
  always_comb begin
    state_next = state;
    grant_en   = 1'b0;
    draining   = 1'b0;
    unique case (state)
      RUN: begin
        grant_en = !frame_start;
        if (frame_start) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        draining = 1'b1;
        if (pipe_empty) begin
          state_next = RUN;
        end
      end
    endcase
  end

  // Search starts just after the last winner, so a lone requester wins back-to-back.
  always_comb begin
    pick_idx = '0;
    pick_any = 1'b0;
    cand     = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(last) + 1 + k) % NUM_REQ;
      if (!pick_any && bus.req[cand]) begin
        pick_any = 1'b1;
        pick_idx = IDX_W'(cand);
      end
    end
  end

  assign accept = grant_en && pick_any && !reset;

  always_comb begin
    gnt = '0;
    if (accept) begin
      gnt[pick_idx] = 1'b1;
    end
  end

  // The tag travels beside the read so the returning byte is steered to its owner.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rd_q    <= 1'b0;
      mem_addr_q  <= '0;
      tag_valid   <= '0;
      tag_idx     <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      last        <= LAST_INIT;
    end else begin
      mem_rd_q <= accept;
      if (accept) begin
        mem_addr_q <= bus.req_addr[pick_idx];
      end
      tag_valid[0] <= accept;
      tag_idx[0]   <= pick_idx;
      for (int s = 1; s <= MEM_LAT; s++) begin
        tag_valid[s] <= tag_valid[s-1];
        tag_idx[s]   <= tag_idx[s-1];
      end
      rsp_valid_q <= '0;
      if (tag_valid[MEM_LAT]) begin
        rsp_valid_q[tag_idx[MEM_LAT]] <= 1'b1;
        rsp_data_q                    <= bus.mem_data;
      end
      if (state == DRAIN) begin
        last <= LAST_INIT;
      end else if (accept) begin
        last <= pick_idx;
      end
    end
  end

  assign bus.gnt       = gnt;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_sprite_fetch_arbiter.sv
// Bench for sprite_fetch_arbiter: a hand-computed cycle table followed by a random
// stress phase with a latency-2 memory model and an in-order response scoreboard.
module tb_sprite_fetch_arbiter;

  localparam int NR  = 4;
  localparam int AW  = 12;
  localparam int LAT = 2;
  localparam int NV  = 38;

  logic clk = 1'b0;
  logic reset;
  logic frame_start;
  logic draining;

  sprite_fetch_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW)) bus ();

  sprite_fetch_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .MEM_LAT(LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .draining    (draining),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        fs;
    logic [3:0]  rq;
    logic [11:0] a0, a1, a2, a3;
    logic [7:0]  md;
    logic        chk;
    logic [3:0]  g;
    logic        rd;
    logic [11:0] ma;
    logic [3:0]  rv;
    logic [7:0]  rdat;
    logic        drn;
  } vec_t;

  typedef struct {
    logic [3:0] onehot;
    logic [7:0] data;
  } exp_t;

  vec_t tbl [NV];
  exp_t sb [$];
  exp_t e;

  int n_vectors     = 0;
  int n_miscompares = 0;

  logic [3:0]       req_r;
  logic [3:0][11:0] addr_r;
  logic [3:0]       acc_prev;
  logic [3:0]       g;
  logic [11:0]      h1, h2;

  function automatic vec_t mk(
    input logic rst, input logic fs, input logic [3:0] rq,
    input logic [11:0] a0, input logic [11:0] a1, input logic [11:0] a2, input logic [11:0] a3,
    input logic [7:0] md, input logic chk,
    input logic [3:0] gg, input logic rd, input logic [11:0] ma,
    input logic [3:0] rv, input logic [7:0] rdat, input logic drn);
    vec_t v;
    v.rst = rst; v.fs = fs; v.rq = rq;
    v.a0 = a0; v.a1 = a1; v.a2 = a2; v.a3 = a3;
    v.md = md; v.chk = chk;
    v.g = gg; v.rd = rd; v.ma = ma; v.rv = rv; v.rdat = rdat; v.drn = drn;
    return v;
  endfunction

  function automatic logic [7:0] mem_hash(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], a[3:0]} ^ 8'h5C;
  endfunction

  task automatic check_output(input string name, input int t,
                              input logic [15:0] act, input logic [15:0] expv);
    n_vectors++;
    if (act !== expv) begin
      n_miscompares++;
      $display("[TB] FAIL %s @%0d: got %h want %h", name, t, act, expv);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    reset         = v.rst;
    frame_start   = v.fs;
    bus.req       = v.rq;
    bus.req_addr  = {v.a3, v.a2, v.a1, v.a0};
    bus.mem_data  = v.md;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // rst fs req  a0      a1      a2      a3      md   chk | gnt rd mem_addr rsp  rdata drn
    tbl[0]  = mk(1,0,4'hF,12'h0A5,12'h000,12'h000,12'h000,8'h00,1, 4'h0,0,12'h000,4'h0,8'h00,0);
    tbl[1]  = mk(0,0,4'h1,12'h0A5,12'h000,12'h000,12'h000,8'h00,1, 4'h1,0,12'h000,4'h0,8'h00,0);
    tbl[2]  = mk(0,0,4'h0,12'h0A5,12'h000,12'h000,12'h000,8'h00,1, 4'h0,1,12'h0A5,4'h0,8'h00,0);
    tbl[3]  = mk(0,0,4'h0,12'h0A5,12'h000,12'h000,12'h000,8'h11,1, 4'h0,0,12'h0A5,4'h0,8'h00,0);
    tbl[4]  = mk(0,0,4'h0,12'h0A5,12'h000,12'h000,12'h000,8'h62,1, 4'h0,0,12'h0A5,4'h0,8'h00,0);
    tbl[5]  = mk(0,0,4'h0,12'h0A5,12'h000,12'h000,12'h000,8'h33,1, 4'h0,0,12'h0A5,4'h1,8'h62,0);
    tbl[6]  = mk(0,1,4'h1,12'h0A5,12'h000,12'h000,12'h000,8'h44,1, 4'h0,0,12'h0A5,4'h0,8'h62,0);
    tbl[7]  = mk(0,1,4'h1,12'h0A5,12'h000,12'h000,12'h000,8'h00,1, 4'h0,0,12'h0A5,4'h0,8'h62,1);
    tbl[8]  = mk(0,0,4'hF,12'h100,12'h201,12'h302,12'h403,8'h00,1, 4'h1,0,12'h0A5,4'h0,8'h62,0);
    tbl[9]  = mk(0,0,4'hF,12'h100,12'h201,12'h302,12'h403,8'h00,1, 4'h2,1,12'h100,4'h0,8'h62,0);
    tbl[10] = mk(0,0,4'hF,12'h100,12'h201,12'h302,12'h403,8'h00,1, 4'h4,1,12'h201,4'h0,8'h62,0);
    tbl[11] = mk(0,0,4'hF,12'h100,12'h201,12'h302,12'h403,8'hA1,1, 4'h8,1,12'h302,4'h0,8'h62,0);
    tbl[12] = mk(0,0,4'hF,12'h100,12'h201,12'h302,12'h403,8'hA2,1, 4'h1,1,12'h403,4'h1,8'hA1,0);
    tbl[13] = mk(0,0,4'hF,12'h100,12'h201,12'h302,12'h403,8'hA3,1, 4'h2,1,12'h100,4'h2,8'hA2,0);
    tbl[14] = mk(0,0,4'hF,12'h100,12'h201,12'h302,12'h403,8'hA4,1, 4'h4,1,12'h201,4'h4,8'hA3,0);
    tbl[15] = mk(0,0,4'hF,12'h100,12'h201,12'h302,12'h403,8'hA5,1, 4'h8,1,12'h302,4'h8,8'hA4,0);
    tbl[16] = mk(0,0,4'h5,12'h0A0,12'h201,12'h2C2,12'h403,8'hA6,1, 4'h1,1,12'h403,4'h1,8'hA5,0);
    tbl[17] = mk(0,0,4'h5,12'h0A0,12'h201,12'h2C2,12'h403,8'hA7,1, 4'h4,1,12'h0A0,4'h2,8'hA6,0);
    tbl[18] = mk(0,1,4'h5,12'h0A0,12'h201,12'h2C2,12'h403,8'hA8,1, 4'h0,1,12'h2C2,4'h4,8'hA7,0);
    tbl[19] = mk(0,0,4'h5,12'h0A0,12'h201,12'h2C2,12'h403,8'hB1,1, 4'h0,0,12'h2C2,4'h8,8'hA8,1);
    tbl[20] = mk(0,0,4'h5,12'h0A0,12'h201,12'h2C2,12'h403,8'hB2,1, 4'h0,0,12'h2C2,4'h1,8'hB1,1);
    tbl[21] = mk(0,0,4'h5,12'h0A0,12'h201,12'h2C2,12'h403,8'h00,1, 4'h0,0,12'h2C2,4'h4,8'hB2,1);
    tbl[22] = mk(0,0,4'h5,12'h0A0,12'h201,12'h2C2,12'h403,8'h00,1, 4'h1,0,12'h2C2,4'h0,8'hB2,0);
    tbl[23] = mk(1,0,4'h1,12'h0A0,12'h201,12'h2C2,12'h403,8'h00,0, 4'h0,0,12'h000,4'h0,8'h00,0);
    tbl[24] = mk(0,0,4'h0,12'h0A0,12'h201,12'h2C2,12'h403,8'h00,1, 4'h0,0,12'h000,4'h0,8'h00,0);
    tbl[25] = mk(0,0,4'h9,12'h055,12'h201,12'h2C2,12'h3FF,8'h5A,1, 4'h1,0,12'h000,4'h0,8'h00,0);
    tbl[26] = mk(0,0,4'h8,12'h055,12'h201,12'h2C2,12'h3FF,8'h00,1, 4'h8,1,12'h055,4'h0,8'h00,0);
    tbl[27] = mk(0,0,4'h0,12'h055,12'h201,12'h2C2,12'h3FF,8'h00,1, 4'h0,1,12'h3FF,4'h0,8'h00,0);
    tbl[28] = mk(0,0,4'h0,12'h055,12'h201,12'h2C2,12'h3FF,8'h77,1, 4'h0,0,12'h3FF,4'h0,8'h00,0);
    tbl[29] = mk(0,0,4'h0,12'h055,12'h201,12'h2C2,12'h3FF,8'h88,1, 4'h0,0,12'h3FF,4'h1,8'h77,0);
    tbl[30] = mk(0,0,4'h0,12'h055,12'h201,12'h2C2,12'h3FF,8'h00,1, 4'h0,0,12'h3FF,4'h8,8'h88,0);
    tbl[31] = mk(0,0,4'h4,12'h055,12'h201,12'h123,12'h3FF,8'h00,1, 4'h4,0,12'h3FF,4'h0,8'h88,0);
    tbl[32] = mk(0,0,4'h4,12'h055,12'h201,12'h124,12'h3FF,8'h00,1, 4'h4,1,12'h123,4'h0,8'h88,0);
    tbl[33] = mk(0,0,4'h0,12'h055,12'h201,12'h124,12'h3FF,8'h00,1, 4'h0,1,12'h124,4'h0,8'h88,0);
    tbl[34] = mk(0,0,4'h0,12'h055,12'h201,12'h124,12'h3FF,8'h9C,1, 4'h0,0,12'h124,4'h0,8'h88,0);
    tbl[35] = mk(0,0,4'h0,12'h055,12'h201,12'h124,12'h3FF,8'h9D,1, 4'h0,0,12'h124,4'h4,8'h9C,0);
    tbl[36] = mk(0,0,4'h0,12'h055,12'h201,12'h124,12'h3FF,8'h00,1, 4'h0,0,12'h124,4'h4,8'h9D,0);
    tbl[37] = mk(0,0,4'h0,12'h055,12'h201,12'h124,12'h3FF,8'h00,1, 4'h0,0,12'h124,4'h0,8'h9D,0);

    reset        = 1'b1;
    frame_start  = 1'b0;
    bus.req      = '0;
    bus.req_addr = '0;
    bus.mem_data = '0;
    repeat (2) @(posedge clk);

    $display("[TB] directed table: %0d cycles", NV);
    for (int t = 0; t < NV; t++) begin
      @(posedge clk);
      #1;
      apply_stimulus(tbl[t]);
      #4;
      check_output("gnt", t, 16'(bus.gnt), 16'(tbl[t].g));
      if (tbl[t].chk) begin
        check_output("mem_rd",    t, 16'(bus.mem_rd),    16'(tbl[t].rd));
        check_output("mem_addr",  t, 16'(bus.mem_addr),  16'(tbl[t].ma));
        check_output("rsp_valid", t, 16'(bus.rsp_valid), 16'(tbl[t].rv));
        check_output("rsp_data",  t, 16'(bus.rsp_data),  16'(tbl[t].rdat));
        check_output("draining",  t, 16'(draining),      16'(tbl[t].drn));
      end
    end

    $display("[TB] random phase with memory model");
    req_r    = '0;
    addr_r   = '0;
    acc_prev = '0;
    h1       = '0;
    h2       = '0;
    for (int cyc = 0; cyc < 10010; cyc++) begin
      @(posedge clk);
      #1;
      if (cyc < 10000) begin
        for (int i = 0; i < NR; i++) begin
          if (req_r[i] && acc_prev[i]) begin
            if ($urandom_range(1, 0) == 1) addr_r[i] = 12'($urandom);
            else req_r[i] = 1'b0;
          end else if (!req_r[i] && $urandom_range(2, 0) != 0) begin
            req_r[i]  = 1'b1;
            addr_r[i] = 12'($urandom);
          end
        end
        frame_start = ($urandom_range(63, 0) == 0);
      end else begin
        req_r       = '0;
        frame_start = 1'b0;
      end
      reset        = 1'b0;
      bus.req      = req_r;
      bus.req_addr = addr_r;
      bus.mem_data = mem_hash(h2);
      #4;
      g = bus.gnt;
      n_vectors++;
      if ($countones(g) > 1 || (g & ~req_r) != 4'h0) begin
        n_miscompares++;
        $display("[TB] FAIL rnd_gnt @%0d: got %h want onehot within req %h", cyc, g, req_r);
      end
      acc_prev = g & req_r;
      if (bus.rsp_valid != 4'h0) begin
        n_vectors++;
        if (sb.size() == 0) begin
          n_miscompares++;
          $display("[TB] FAIL rnd_rsp @%0d: got rsp_valid %h want none outstanding", cyc, bus.rsp_valid);
        end else begin
          e = sb.pop_front();
          if (bus.rsp_valid !== e.onehot || bus.rsp_data !== e.data) begin
            n_miscompares++;
            $display("[TB] FAIL rnd_rsp @%0d: got %h/%h want %h/%h",
                     cyc, bus.rsp_valid, bus.rsp_data, e.onehot, e.data);
          end
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (acc_prev[i]) begin
          e.onehot = 4'(1 << i);
          e.data   = mem_hash(addr_r[i]);
          sb.push_back(e);
        end
      end
      h2 = h1;
      h1 = bus.mem_addr;
    end
    check_output("rnd_outstanding", 0, 16'(sb.size()), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
